// File: rtl/square_motion_ctrl.sv
// Frame-synchronous sprite position controller: steps x/y once per vsync rising edge and bounces at screen edges.
// x settles 2 cycles and y 3 cycles after the tick; no backpressure, a load pulse overrides any state.
module square_motion_ctrl #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 64,
  parameter int X0       = 0,
  parameter int Y0       = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        run,
  input  logic        load,
  input  logic [10:0] load_x,
  input  logic [9:0]  load_y,
  input  logic [3:0]  dx,
  input  logic [3:0]  dy,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        bounce,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    MOVE_X = 2'd2,
    MOVE_Y = 2'd3
  } state_t;

  localparam logic [11:0] XMAX = 12'(SCREEN_W - WIDTH);
  localparam logic [11:0] YMAX = 12'(SCREEN_H - HEIGHT);

  state_t state;
  state_t state_nxt;
  logic   vsync_d;
  logic   tick;

  logic [11:0] x_sum;
  logic [10:0] x_dec;
  logic [10:0] x_step;
  logic        dir_x_step;
  logic        x_flip;

  logic [11:0] y_sum;
  logic [9:0]  y_dec;
  logic [9:0]  y_step;
  logic        dir_y_step;
  logic        y_flip;

  logic [10:0] load_x_clamped;
  logic [9:0]  load_y_clamped;

  assign tick = vsync & ~vsync_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a load aborts whatever frame is in flight
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = run ? WAIT : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) state_nxt = WAIT;
        end
        WAIT: begin
          if (!run)      state_nxt = IDLE;
          else if (tick) state_nxt = MOVE_X;
        end
        MOVE_X: begin
          state_nxt = MOVE_Y;
        end
        MOVE_Y: begin
          state_nxt = run ? WAIT : IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    if (state == MOVE_X || state == MOVE_Y) busy = 1'b1;
  end

  // X step: 12-bit sum so the right-edge test cannot wrap
  assign x_sum = {1'b0, x} + {8'b0, dx};
  assign x_dec = x - {7'b0, dx};

  always_comb begin
    x_step     = x;
    dir_x_step = dir_x;
    x_flip     = 1'b0;
    if (dx != 4'd0) begin
      if (dir_x) begin
        if (x_sum >= XMAX) begin
          x_step     = XMAX[10:0];
          dir_x_step = 1'b0;
          x_flip     = 1'b1;
        end else begin
          x_step = x_sum[10:0];
        end
      end else begin
        if ({1'b0, x} <= {8'b0, dx}) begin
          x_step     = 11'd0;
          dir_x_step = 1'b1;
          x_flip     = 1'b1;
        end else begin
          x_step = x_dec;
        end
      end
    end
  end

  assign y_sum = {2'b0, y} + {8'b0, dy};
  assign y_dec = y - {6'b0, dy};

  always_comb begin
    y_step     = y;
    dir_y_step = dir_y;
    y_flip     = 1'b0;
    if (dy != 4'd0) begin
      if (dir_y) begin
        if (y_sum >= YMAX) begin
          y_step     = YMAX[9:0];
          dir_y_step = 1'b0;
          y_flip     = 1'b1;
        end else begin
          y_step = y_sum[9:0];
        end
      end else begin
        if ({2'b0, y} <= {8'b0, dy}) begin
          y_step     = 10'd0;
          dir_y_step = 1'b1;
          y_flip     = 1'b1;
        end else begin
          y_step = y_dec;
        end
      end
    end
  end

  // Loaded positions saturate at the edge limits rather than wrapping
  assign load_x_clamped = ({1'b0, load_x} > XMAX) ? XMAX[10:0] : load_x;
  assign load_y_clamped = ({2'b0, load_y} > YMAX) ? YMAX[9:0]  : load_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d <= 1'b0;
      x       <= 11'(X0);
      y       <= 10'(Y0);
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
      bounce  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      bounce  <= 1'b0;
      if (load) begin
        x     <= load_x_clamped;
        y     <= load_y_clamped;
        dir_x <= 1'b1;
        dir_y <= 1'b1;
      end else if (state == MOVE_X) begin
        x      <= x_step;
        dir_x  <= dir_x_step;
        bounce <= x_flip;
      end else if (state == MOVE_Y) begin
        y      <= y_step;
        dir_y  <= dir_y_step;
        bounce <= y_flip;
      end
    end
  end

endmodule
